// File: rtl/test_master_slave1_reader.sv
// Receiving end of the TestMasterSlave1 link: sums BATCH unhandshaked samples of the
// master's shared variable and emits each signed sum over a blocking notify/sync port.
module test_master_slave1_reader #(
  parameter int BATCH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_in,
  output logic [WIDTH-1:0] b_out_data,
  output logic             b_out_ovf,
  output logic             b_out_notify,
  input  logic             b_out_sync,
  output logic [7:0]       batch_cnt
);

  typedef enum logic {SECTION_A, SECTION_B} section_t;

  localparam logic [7:0] LAST = 8'(BATCH - 1);

  section_t         r_section;
  logic [WIDTH-1:0] r_acc;
  logic [7:0]       r_cnt;
  logic             r_ovf;
  logic [WIDTH-1:0] r_data;
  logic             r_data_ovf;
  logic             r_notify;
  logic [7:0]       r_batch_cnt;

  logic [WIDTH-1:0] w_sum;
  logic             w_ovf_now;

  // Signed overflow: both operands agree in sign but the wrapped sum does not.
  assign w_sum     = r_acc + s_in;
  assign w_ovf_now = (r_acc[WIDTH-1] == s_in[WIDTH-1]) && (w_sum[WIDTH-1] != r_acc[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_section   <= SECTION_A;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_data      <= '0;
      r_data_ovf  <= 1'b0;
      r_notify    <= 1'b0;
      r_batch_cnt <= '0;
    end else begin
      case (r_section)
        SECTION_A: begin
          if (r_cnt == LAST) begin
            r_data     <= w_sum;
            r_data_ovf <= r_ovf | w_ovf_now;
            r_notify   <= 1'b1;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_section  <= SECTION_B;
          end else begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_ovf_now;
            r_cnt <= r_cnt + 8'd1;
          end
        end
        SECTION_B: begin
          // s_in is deliberately ignored here: samples during emit are dropped.
          if (r_notify && b_out_sync) begin
            r_notify    <= 1'b0;
            r_batch_cnt <= r_batch_cnt + 8'd1;
            r_section   <= SECTION_A;
          end
        end
        default: r_section <= SECTION_A;
      endcase
    end
  end

  assign b_out_data   = r_data;
  assign b_out_ovf    = r_data_ovf;
  assign b_out_notify = r_notify;
  assign batch_cnt    = r_batch_cnt;

endmodule

// File: tb/tb_test_master_slave1_reader.sv
// Scoreboarded bench: a sample-list reference model pushes expected batch results,
// a negedge monitor compares them against the DUT; a BATCH=1 instance runs alongside.
module tb_test_master_slave1_reader;

  localparam int BATCH = 4;

  typedef struct packed {
    logic [31:0] d;
    logic        o;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_in = '0;
  logic        sync = 1'b0;
  logic [31:0] data;
  logic        ovf, notify;
  logic [7:0]  bcnt;

  logic [31:0] s1_in = 32'd9;
  logic        sync1 = 1'b1;
  logic [31:0] data1;
  logic        ovf1, notify1;
  logic [7:0]  bcnt1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  test_master_slave1_reader #(.BATCH(BATCH), .WIDTH(32)) u0 (
    .clk(clk), .rst(rst), .s_in(s_in), .b_out_data(data), .b_out_ovf(ovf),
    .b_out_notify(notify), .b_out_sync(sync), .batch_cnt(bcnt));

  test_master_slave1_reader #(.BATCH(1), .WIDTH(32)) u1 (
    .clk(clk), .rst(rst), .s_in(s1_in), .b_out_data(data1), .b_out_ovf(ovf1),
    .b_out_notify(notify1), .b_out_sync(sync1), .batch_cnt(bcnt1));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a batch is just the list of samples taken while not emitting;
  // the sum is plain integer arithmetic, overflow is any out-of-range partial sum.
  res_t   exp_q[$];
  bit     m_emit;
  int     m_n;
  int     m_acc;
  bit     m_ovf;
  int     m_cnt;
  bit     m1_emit;
  int     m1_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_emit = 0; m_n = 0; m_acc = 0; m_ovf = 0; m_cnt = 0;
      exp_q.delete();
      m1_emit = 0; m1_cnt = 0;
    end else begin
      if (!m_emit) begin
        longint full;
        full = longint'(m_acc) + longint'($signed(s_in));
        if (full > 64'sd2147483647 || full < -64'sd2147483648) m_ovf = 1;
        m_acc = int'(full);
        m_n++;
        if (m_n == BATCH) begin
          exp_q.push_back('{d: m_acc, o: m_ovf});
          m_emit = 1; m_n = 0; m_acc = 0; m_ovf = 0;
        end
      end else if (sync) begin
        m_emit = 0;
        m_cnt++;
      end
      if (!m1_emit) m1_emit = 1;
      else begin
        m1_emit = 0;
        m1_cnt++;
      end
    end
  end

  // Monitor: compares whatever the DUTs present each cycle against the model.
  always @(negedge clk) begin
    chk("notify", {63'd0, notify}, {63'd0, m_emit});
    chk("batch_cnt", {56'd0, bcnt}, 64'(m_cnt % 256));
    if (notify) begin
      if (exp_q.size() == 0) chk("queue_nonempty", 64'd0, 64'd1);
      else begin
        chk("data", {32'd0, data}, {32'd0, exp_q[0].d});
        chk("ovf", {63'd0, ovf}, {63'd0, exp_q[0].o});
        if (sync) void'(exp_q.pop_front());
      end
    end
    chk("b1_notify", {63'd0, notify1}, {63'd0, m1_emit});
    chk("b1_batch_cnt", {56'd0, bcnt1}, 64'(m1_cnt % 256));
    if (notify1) chk("b1_data", {32'd0, data1}, 64'd9);
  end

  task automatic step(input logic [31:0] v, input logic sy);
    s_in = v;
    sync = sy;
    @(posedge clk);
    #1;
  endtask

  task automatic batch(input logic [31:0] a, b, c, d);
    step(a, 0); step(b, 0); step(c, 0); step(d, 0);
  endtask

  task automatic wait_notify(input string nm, input logic [31:0] ed, input logic eo,
                             input logic [7:0] ec);
    int i;
    for (i = 0; i < 20 && !notify; i++) step(s_in, 0);
    if (!notify) chk({nm, "_timeout"}, 64'd0, 64'd1);
    else begin
      chk({nm, "_data"}, {32'd0, data}, {32'd0, ed});
      chk({nm, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
      chk({nm, "_cnt"}, {56'd0, bcnt}, {56'd0, ec});
    end
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 4))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  task automatic mid_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_data", {32'd0, data}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_notify", {63'd0, notify}, 64'd0);
    chk("rst_cnt", {56'd0, bcnt}, 64'd0);
    chk("rst_b1_notify", {63'd0, notify1}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step(32'd3, 0);
    step(32'd4, 0);
    mid_reset();

    batch(32'd5, 32'd5, 32'd5, 32'd5);
    wait_notify("five", 32'd20, 1'b0, 8'd0);
    step(rnd(), 1);

    batch(32'd1, 32'd2, 32'd3, 32'd4);
    wait_notify("bp", 32'd10, 1'b0, 8'd1);
    repeat (10) step(rnd(), 0);
    chk("bp_hold", {32'd0, data}, 64'd10);
    step(rnd(), 1);

    batch(-32'sd7, 32'd3, -32'sd2, 32'd1);
    wait_notify("signed", 32'hFFFFFFFB, 1'b0, 8'd2);
    step(rnd(), 1);

    batch(32'h7FFFFFFF, 32'd1, 32'd0, 32'd0);
    wait_notify("ovf", 32'h80000000, 1'b1, 8'd3);
    step(rnd(), 1);

    batch(32'd1, 32'd1, 32'd1, 32'd1);
    wait_notify("ovf_clr", 32'd4, 1'b0, 8'd4);

    // One transfer plus exactly three back-to-back 5-cycle batches.
    repeat (16) step(rnd(), 1);
    batch(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_notify("stream", 32'hFFFFFFFC, 1'b0, 8'd8);

    mid_reset();
    batch(32'd5, 32'd5, 32'd5, 32'd5);
    wait_notify("post_rst", 32'd20, 1'b0, 8'd0);
    step(rnd(), 1);

    repeat (400) step(rnd(), 1'($urandom_range(0, 1)));
    repeat (10) step(rnd(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
